// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile writeback scheduler.
// Optional build macro: REGFILE_WB_FIXED_PRIO_EN (LSU wins ties, no round-robin state).
package regfile_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

    // Writeback requester identity; also the encoding of last_grant.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

    // True when the index names the hardwired-zero register.
    function automatic logic is_zero_reg(input logic [REG_IDX_W-1:0] idx);
        return (idx == ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_wb_sched_rr_arb2.sv
// Two-input writeback arbiter (ALU vs LSU).
// Default: round-robin with last_grant held here, LSU as reset value so the ALU wins the first tie.
// With REGFILE_WB_FIXED_PRIO_EN defined: LSU always wins a tie and no state is kept.
module rr_arb2
    import regfile_pkg::*;
(
`ifndef REGFILE_WB_FIXED_PRIO_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic i_req_alu,
    input  logic i_req_lsu,
    output logic o_gnt_alu_c,
    output logic o_gnt_lsu_c
);

`ifndef REGFILE_WB_FIXED_PRIO_EN
    req_id_t r_last_grant;

    // Grant the sole requester, or on a tie the one that did not win last time.
    always_comb begin
        o_gnt_alu_c = 1'b0;
        o_gnt_lsu_c = 1'b0;
        if (i_req_alu && i_req_lsu) begin
            o_gnt_alu_c = (r_last_grant == REQ_LSU);
            o_gnt_lsu_c = (r_last_grant == REQ_ALU);
        end else begin
            o_gnt_alu_c = i_req_alu;
            o_gnt_lsu_c = i_req_lsu;
        end
    end

    // Track the winner of every completed handshake (ready == grant, so every grant completes).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= REQ_LSU;
        end else if (o_gnt_alu_c) begin
            r_last_grant <= REQ_ALU;
        end else if (o_gnt_lsu_c) begin
            r_last_grant <= REQ_LSU;
        end
    end
`else
    // Fixed priority: loads must never back up the memory pipe.
    always_comb begin
        o_gnt_lsu_c = i_req_lsu;
        o_gnt_alu_c = i_req_alu && !i_req_lsu;
    end
`endif

endmodule

// File: rtl/regfile_wb_sched.sv
// Regfile writeback scheduler: arbitrates ALU/LSU onto the single regfile write port through a
// registered write stage, suppresses x0 writes and keeps a pending-write scoreboard for RAW stalls.
// Optional build macro: REGFILE_WB_FIXED_PRIO_EN (selects fixed LSU priority in rr_arb2).
module regfile_wb_sched
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [REG_IDX_W-1:0] alu_idx,
    input  logic [XLEN-1:0]      alu_data,

    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [REG_IDX_W-1:0] lsu_idx,
    input  logic [XLEN-1:0]      lsu_data,

    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_idx,
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    output logic                 rs1_busy,
    output logic                 rs2_busy,

    output logic                 rf_write_enable,
    output logic [REG_IDX_W-1:0] rf_write_idx,
    output logic [XLEN-1:0]      rf_write_data
);

    logic                 w_req_alu;
    logic                 w_req_lsu;
    logic                 w_gnt_alu;
    logic                 w_gnt_lsu;
    logic                 w_hs;
    logic [REG_IDX_W-1:0] w_sel_idx;
    logic [XLEN-1:0]      w_sel_data;
    logic [NUM_REGS-1:0]  w_busy_nxt;

    logic                 r_we;
    logic [REG_IDX_W-1:0] r_idx;
    logic [XLEN-1:0]      r_data;
    logic [NUM_REGS-1:0]  r_busy;

    // Requests are masked during reset so ready reads 0 while rst is high.
    always_comb begin
        w_req_alu = alu_valid && !rst;
        w_req_lsu = lsu_valid && !rst;
    end

    rr_arb2 u_arb (
`ifndef REGFILE_WB_FIXED_PRIO_EN
        .clk         (clk),
        .rst         (rst),
`endif
        .i_req_alu   (w_req_alu),
        .i_req_lsu   (w_req_lsu),
        .o_gnt_alu_c (w_gnt_alu),
        .o_gnt_lsu_c (w_gnt_lsu)
    );

    // Write stage always accepts, so ready is simply the grant; mux the winner's payload.
    always_comb begin
        alu_ready  = w_gnt_alu;
        lsu_ready  = w_gnt_lsu;
        w_hs       = w_gnt_alu || w_gnt_lsu;
        w_sel_idx  = w_gnt_lsu ? lsu_idx  : alu_idx;
        w_sel_data = w_gnt_lsu ? lsu_data : alu_data;
    end

    // Registered write stage; x0 writes complete the handshake but never enable the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_idx  <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_hs && !is_zero_reg(w_sel_idx);
            if (w_hs) begin
                r_idx  <= w_sel_idx;
                r_data <= w_sel_data;
            end
        end
    end

    // Scoreboard next state: clear on the write cycle, then a same-cycle issue re-sets (set wins).
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we) begin
            w_busy_nxt[r_idx] = 1'b0;
        end
        if (issue_valid && !is_zero_reg(issue_idx)) begin
            w_busy_nxt[issue_idx] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register; bit 0 stays clear so x0 never reads busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Port-side views of the write stage and scoreboard lookups.
    always_comb begin
        rf_write_enable = r_we;
        rf_write_idx    = r_idx;
        rf_write_data   = r_data;
        rs1_busy        = r_busy[rs1_idx];
        rs2_busy        = r_busy[rs2_idx];
    end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed testbench for regfile_wb_sched: reset, arbitration, write stage, x0 and scoreboard.
module tb_regfile_wb_sched;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_idx;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_idx;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_idx;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_write_enable;
    logic [4:0]  rf_write_idx;
    logic [31:0] rf_write_data;

    int checks;
    int failures;

    regfile_wb_sched dut (
        .clk             (clk),
        .rst             (rst),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_idx         (alu_idx),
        .alu_data        (alu_data),
        .lsu_valid       (lsu_valid),
        .lsu_ready       (lsu_ready),
        .lsu_idx         (lsu_idx),
        .lsu_data        (lsu_data),
        .issue_valid     (issue_valid),
        .issue_idx       (issue_idx),
        .rs1_idx         (rs1_idx),
        .rs2_idx         (rs2_idx),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .rf_write_enable (rf_write_enable),
        .rf_write_idx    (rf_write_idx),
        .rf_write_data   (rf_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_alu_gnt;

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        alu_valid   = 1'b1;
        alu_idx     = 5'd1;
        alu_data    = 32'h0;
        lsu_valid   = 1'b1;
        lsu_idx     = 5'd2;
        lsu_data    = 32'h0;
        issue_valid = 1'b1;
        issue_idx   = 5'd4;
        rs1_idx     = 5'd4;
        rs2_idx     = 5'd0;

        // Reset held with requests present: every output must read 0.
        #12;
        check_eq("rst_alu_ready", 32'(alu_ready), 32'd0);
        check_eq("rst_lsu_ready", 32'(lsu_ready), 32'd0);
        check_eq("rst_we",        32'(rf_write_enable), 32'd0);
        check_eq("rst_idx",       32'(rf_write_idx), 32'd0);
        check_eq("rst_data",      rf_write_data, 32'd0);
        check_eq("rst_rs1_busy",  32'(rs1_busy), 32'd0);
        check_eq("rst_rs2_busy",  32'(rs2_busy), 32'd0);

        alu_valid   = 1'b0;
        lsu_valid   = 1'b0;
        issue_valid = 1'b0;
        cyc();
        rst = 1'b0;

        // Idle after release.
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_eq("idle_we", 32'(rf_write_enable), 32'd0);
        end

        // Both valid for 4 cycles: ALU,LSU,ALU,LSU (round-robin) or LSU x4 (fixed priority).
`ifdef REGFILE_WB_FIXED_PRIO_EN
        exp_alu_gnt = 4'b0000;
`else
        exp_alu_gnt = 4'b0101;
`endif
        alu_valid = 1'b1; alu_idx = 5'd1; alu_data = 32'h1111_1111;
        lsu_valid = 1'b1; lsu_idx = 5'd2; lsu_data = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("tie_alu_ready", 32'(alu_ready), 32'(exp_alu_gnt[i]));
            check_eq("tie_lsu_ready", 32'(lsu_ready), 32'(!exp_alu_gnt[i]));
            cyc();
            check_eq("tie_we",   32'(rf_write_enable), 32'd1);
            check_eq("tie_idx",  32'(rf_write_idx), exp_alu_gnt[i] ? 32'd1 : 32'd2);
            check_eq("tie_data", rf_write_data, exp_alu_gnt[i] ? 32'h1111_1111 : 32'h2222_2222);
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        cyc();
        check_eq("tie_drain_we", 32'(rf_write_enable), 32'd0);

        // ALU only: ready in N, write visible in N+1, enable drops in N+2 with payload held.
        alu_valid = 1'b1; alu_idx = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1;
        check_eq("alu_ready", 32'(alu_ready), 32'd1);
        check_eq("alu_lsu_ready", 32'(lsu_ready), 32'd0);
        cyc();
        alu_valid = 1'b0;
        check_eq("alu_we",   32'(rf_write_enable), 32'd1);
        check_eq("alu_idx",  32'(rf_write_idx), 32'd5);
        check_eq("alu_data", rf_write_data, 32'hDEAD_BEEF);
        cyc();
        check_eq("alu_we_off",    32'(rf_write_enable), 32'd0);
        check_eq("alu_idx_hold",  32'(rf_write_idx), 32'd5);
        check_eq("alu_data_hold", rf_write_data, 32'hDEAD_BEEF);

        // Scoreboard: issue x7, busy until the edge ending the LSU write cycle for x7.
        issue_valid = 1'b1; issue_idx = 5'd7; rs1_idx = 5'd7; rs2_idx = 5'd6;
        #1;
        check_eq("sb_pre_busy", 32'(rs1_busy), 32'd0);
        cyc();
        issue_valid = 1'b0;
        #1;
        check_eq("sb_rs1_busy", 32'(rs1_busy), 32'd1);
        check_eq("sb_rs2_idle", 32'(rs2_busy), 32'd0);
        cyc();
        check_eq("sb_rs1_hold", 32'(rs1_busy), 32'd1);
        lsu_valid = 1'b1; lsu_idx = 5'd7; lsu_data = 32'hCAFE_0007;
        #1;
        check_eq("sb_lsu_ready", 32'(lsu_ready), 32'd1);
        cyc();
        lsu_valid = 1'b0;
        check_eq("sb_wr_we",   32'(rf_write_enable), 32'd1);
        check_eq("sb_wr_idx",  32'(rf_write_idx), 32'd7);
        check_eq("sb_wr_busy", 32'(rs1_busy), 32'd1);
        cyc();
        check_eq("sb_cleared", 32'(rs1_busy), 32'd0);

        // Issue to x7 in the same cycle its write retires: set wins.
        issue_valid = 1'b1; issue_idx = 5'd7;
        cyc();
        issue_valid = 1'b0;
        lsu_valid = 1'b1; lsu_idx = 5'd7; lsu_data = 32'h0000_0777;
        cyc();
        lsu_valid = 1'b0;
        issue_valid = 1'b1; issue_idx = 5'd7; rs2_idx = 5'd7;
        #1;
        check_eq("setwin_we",   32'(rf_write_enable), 32'd1);
        check_eq("setwin_rs2",  32'(rs2_busy), 32'd1);
        cyc();
        issue_valid = 1'b0;
        #1;
        check_eq("setwin_rs1",  32'(rs1_busy), 32'd1);

        // x0 write: handshake completes, port stays disabled, x0 never busy.
        alu_valid = 1'b1; alu_idx = 5'd0; alu_data = 32'h0000_0055;
        rs1_idx = 5'd0; issue_valid = 1'b1; issue_idx = 5'd0;
        #1;
        check_eq("x0_ready", 32'(alu_ready), 32'd1);
        cyc();
        alu_valid = 1'b0; issue_valid = 1'b0;
        #1;
        check_eq("x0_we",   32'(rf_write_enable), 32'd0);
        check_eq("x0_idx",  32'(rf_write_idx), 32'd0);
        check_eq("x0_data", rf_write_data, 32'h0000_0055);
        check_eq("x0_busy", 32'(rs1_busy), 32'd0);
        check_eq("x7_still_busy", 32'(rs2_busy), 32'd1);

        // Reset while an LSU write to x3 sits in the write stage.
        issue_valid = 1'b1; issue_idx = 5'd3;
        cyc();
        issue_valid = 1'b0;
        lsu_valid = 1'b1; lsu_idx = 5'd3; lsu_data = 32'h0000_0033; rs1_idx = 5'd3;
        #1;
        check_eq("mid_busy3",  32'(rs1_busy), 32'd1);
        check_eq("mid_ready",  32'(lsu_ready), 32'd1);
        cyc();
        lsu_valid = 1'b0;
        check_eq("mid_we",     32'(rf_write_enable), 32'd1);
        check_eq("mid_idx",    32'(rf_write_idx), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_we",    32'(rf_write_enable), 32'd0);
        check_eq("arst_idx",   32'(rf_write_idx), 32'd0);
        check_eq("arst_busy3", 32'(rs1_busy), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        #1;
        check_eq("post_busy3", 32'(rs1_busy), 32'd0);
        check_eq("post_busy7", 32'(rs2_busy), 32'd0);
        check_eq("post_we",    32'(rf_write_enable), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Shares the register file's single write port between two writeback requesters: ALU (req 0) and load/store unit (req 1).
- Uses valid/ready handshakes, round-robin arbitration, a registered write stage, x0 write suppression and a pending-write scoreboard.
- The issue stage uses the scoreboard for RAW stall decisions.
- Sits between the execute/memory units and the regfile write port (write_enable/write_idx/write_data).

Parameters:
- XLEN, 32, data width of writeback values.
- REG_IDX_W, 5, register index width.
- NUM_REGS, 32, architectural register count; index 0 is hardwired zero.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_idx  in  REG_IDX_W  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  LSU writeback request.
- lsu_ready  out  1  LSU request accepted this cycle.
- lsu_idx  in  REG_IDX_W  LSU destination register.
- lsu_data  in  XLEN  load data.
- issue_valid  in  1  an instruction with a destination issues this cycle.
- issue_idx  in  REG_IDX_W  its destination register.
- rs1_idx  in  REG_IDX_W  issue-stage source 1.
- rs2_idx  in  REG_IDX_W  issue-stage source 2.
- rs1_busy  out  1  rs1 has an outstanding write.
- rs2_busy  out  1  rs2 has an outstanding write.
- rf_write_enable  out  1  to regfile write_enable.
- rf_write_idx  out  REG_IDX_W  to regfile write_idx.
- rf_write_data  out  XLEN  to regfile write_data.

Behaviour:
- Reset: asynchronous, active-high. All outputs are 0 while rst is high and after release: rf_write_enable, rf_write_idx, rf_write_data, alu_ready, lsu_ready, rs1_busy, rs2_busy. Scoreboard is cleared and last_grant = 1 (LSU), so the ALU wins the first tie.
- Arbitration (combinational, each cycle):
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - Neither valid: no grant.
  - ready = grant. The handshake completes in a cycle when valid & ready. last_grant updates on every completed handshake.
- The write stage always accepts, so ready never depends on downstream state.
- Requesters must hold idx/data stable while valid and not ready. Dropping valid before acceptance is legal; the request is simply withdrawn.
- Write stage (registered):
  - On a handshake in cycle N, rf_write_idx/rf_write_data capture the granted idx/data at the edge ending N.
  - rf_write_enable is 1 during cycle N+1 iff the captured idx != 0.
  - The regfile updates at the edge ending N+1. Latency from handshake to architectural visibility: 2 edges.
  - No handshake: rf_write_enable = 0 the next cycle; idx/data hold their previous values.
- x0 writes: the handshake completes normally, but rf_write_enable stays 0 and the scoreboard is unaffected.
- Scoreboard busy[NUM_REGS-1:1]:
  - Set at the edge when issue_valid & issue_idx != 0.
  - Cleared at the edge ending the cycle where rf_write_enable = 1 for that idx, which is the same edge the regfile updates.
  - Set and clear on the same idx in the same cycle: set wins (a new producer is outstanding).
  - Issuing to an already-busy register keeps it busy. There is no counting: one outstanding producer per register is assumed by issue-stage policy.
- rsN_busy = busy[rsN_idx] combinationally; 0 when rsN_idx == 0.
- Reset mid-operation: the in-flight write stage is discarded (rf_write_enable forced 0) and the scoreboard is cleared. Requesters must reissue.

Optional Feature:
- Macro REGFILE_WB_FIXED_PRIO_EN.
- Defined: fixed priority, LSU always wins a tie (loads complete with long latency and must not back up the memory pipe). last_grant is not implemented.
- Undefined: round-robin as above.

Decomposition:
- Shared package regfile_pkg: XLEN, REG_IDX_W, NUM_REGS, ZERO_REG = 0, requester id typedef (REQ_ALU = 0, REQ_LSU = 1).
- Sub-module rr_arb2: 2-input round-robin/fixed-priority arbiter holding last_grant; the macro selects its mode.
- Scoreboard and write stage stay inline.

Test Plan:
- Reset, then idle: all outputs 0. Release rst and drive no requests for 5 cycles -> rf_write_enable remains 0.
- ALU only, idx 5, data 0xDEADBEEF in cycle N -> alu_ready = 1 in N; rf_write_enable = 1, rf_write_idx = 5, rf_write_data = 0xDEADBEEF in N+1; 0 in N+2.
- Both valid for 4 consecutive cycles (ALU idx 1, LSU idx 2) -> grants ALU, LSU, ALU, LSU. With REGFILE_WB_FIXED_PRIO_EN -> LSU all 4 cycles, alu_ready stays 0.
- Issue idx 7, then rs1_idx = 7 -> rs1_busy = 1 until the cycle after a LSU writeback of idx 7 appears on the write port; rs1_busy = 0 from the edge ending that write cycle.
- Writeback to idx 7 in the same cycle as issue_valid to idx 7 -> busy[7] remains 1. Write to idx 0 -> handshake completes, rf_write_enable = 0, rs1_busy for idx 0 = 0.
- Assert rst while an LSU write is in the write stage with busy[3] = 1 -> rf_write_enable = 0 immediately (asynchronous), rs busy for idx 3 = 0 after release.
